tile_transposer: RTL and testbench

//  Streaming NxN element tile transposer with ping-pong tile banks. Rows arrive as N-element beats;

---
 rtl/tile_transposer.sv | 122 ++++++++++++
 tb/tb_tile_transposer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_transposer.sv
// Streaming NxN tile transposer: rows in, columns out, two ping-pong tile banks.
// Optional TILE_TRANSPOSER_STALL_CNT_EN adds in_stall_cnt/out_stall_cnt stall counters.
module tile_transposer #(
    parameter int EW = 8,
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            cfg_bypass,
    input  logic [N*EW-1:0] in_data,
    input  logic            in_last,
    input  logic            in_vld,
    output logic            in_rdy,
    output logic [N*EW-1:0] out_data,
    output logic            out_last,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic            tile_done,
`ifdef TILE_TRANSPOSER_STALL_CNT_EN
    output logic [31:0]     in_stall_cnt,
    output logic [31:0]     out_stall_cnt,
`endif
    output logic [CW-1:0]   tile_cnt
);

    localparam int AW = $clog2(N);

    typedef logic [N-1:0][EW-1:0] row_t;

    row_t          bank [2][N];
    logic [AW:0]   rows [2];
    logic [1:0]    full;
    logic [1:0]    byp;
    logic          wb;
    logic          rb;
    logic [AW-1:0] wr_row;
    logic [AW-1:0] rd_col;

    logic in_fire, out_fire, in_close, out_close;

    assign in_rdy    = !reset && !clear && !full[wb];
    assign out_vld   = !reset && !clear && full[rb];
    assign in_fire   = in_vld && in_rdy;
    assign out_fire  = out_vld && out_rdy;
    assign in_close  = in_fire && (in_last || wr_row == AW'(N-1));
    assign out_close = out_fire && (rd_col == AW'(N-1));
    assign out_last  = out_vld && (rd_col == AW'(N-1));
    assign tile_done = out_close;

    // wb and rb can never name the same bank in a cycle where both fire,
    // so the close and drain updates to full[] never collide.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full     <= '0;
            byp      <= '0;
            rows[0]  <= '0;
            rows[1]  <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            wr_row   <= '0;
            rd_col   <= '0;
            tile_cnt <= '0;
        end else begin
            if (in_fire) begin
                if (wr_row == '0)
                    byp[wb] <= cfg_bypass;
                if (in_close) begin
                    full[wb] <= 1'b1;
                    rows[wb] <= {1'b0, wr_row} + (AW+1)'(1);
                    wr_row   <= '0;
                    wb       <= ~wb;
                end else begin
                    wr_row <= wr_row + AW'(1);
                end
            end
            if (out_fire) begin
                if (out_close) begin
                    full[rb] <= 1'b0;
                    rd_col   <= '0;
                    rb       <= ~rb;
                    tile_cnt <= tile_cnt + CW'(1);
                end else begin
                    rd_col <= rd_col + AW'(1);
                end
            end
        end
    end

    // Tile storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (in_fire)
            bank[wb][wr_row] <= in_data;
    end

    // Rows past the tile's row count are masked to zero on read.
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [EW-1:0] t_elem;
        logic [EW-1:0] b_elem;
        assign t_elem = ((AW+1)'(r) < rows[rb]) ? bank[rb][r][rd_col] : '0;
        assign b_elem = ({1'b0, rd_col} < rows[rb]) ? bank[rb][rd_col][r] : '0;
        assign out_data[r*EW +: EW] = !out_vld ? '0 : (byp[rb] ? b_elem : t_elem);
    end

`ifdef TILE_TRANSPOSER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            in_stall_cnt  <= '0;
            out_stall_cnt <= '0;
        end else begin
            if (in_vld && !in_rdy && in_stall_cnt != '1)
                in_stall_cnt <= in_stall_cnt + 32'd1;
            if (out_vld && !out_rdy && out_stall_cnt != '1)
                out_stall_cnt <= out_stall_cnt + 32'd1;
        end
    end
`else
    // Without the option no stall statistics are kept.
`endif

endmodule

// File: tb/tb_tile_transposer.sv
// Scoreboard bench: N=4/EW=8 directed tests plus an N=8/EW=16 random stream.
module tb_tile_transposer;
    localparam int AN = 4, AEW = 8, BN = 8, BEW = 16, CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           a_reset, a_clear, a_cfg_bypass, a_in_last, a_in_vld, a_in_rdy;
    logic           a_out_last, a_out_vld, a_out_rdy, a_tile_done;
    logic [31:0]    a_in_data, a_out_data;
    logic [CW-1:0]  a_tile_cnt;
    logic           b_reset, b_clear, b_cfg_bypass, b_in_last, b_in_vld, b_in_rdy;
    logic           b_out_last, b_out_vld, b_out_rdy, b_tile_done;
    logic [127:0]   b_in_data, b_out_data;
    logic [CW-1:0]  b_tile_cnt;
`ifdef TILE_TRANSPOSER_STALL_CNT_EN
    logic [31:0]    a_isc, a_osc, b_isc, b_osc;
`endif

    tile_transposer #(.EW(AEW), .N(AN), .CW(CW)) dut_a (
        .clk(clk), .reset(a_reset), .clear(a_clear), .cfg_bypass(a_cfg_bypass),
        .in_data(a_in_data), .in_last(a_in_last), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
        .out_data(a_out_data), .out_last(a_out_last), .out_vld(a_out_vld), .out_rdy(a_out_rdy),
        .tile_done(a_tile_done),
`ifdef TILE_TRANSPOSER_STALL_CNT_EN
        .in_stall_cnt(a_isc), .out_stall_cnt(a_osc),
`endif
        .tile_cnt(a_tile_cnt));

    tile_transposer #(.EW(BEW), .N(BN), .CW(CW)) dut_b (
        .clk(clk), .reset(b_reset), .clear(b_clear), .cfg_bypass(b_cfg_bypass),
        .in_data(b_in_data), .in_last(b_in_last), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
        .out_data(b_out_data), .out_last(b_out_last), .out_vld(b_out_vld), .out_rdy(b_out_rdy),
        .tile_done(b_tile_done),
`ifdef TILE_TRANSPOSER_STALL_CNT_EN
        .in_stall_cnt(b_isc), .out_stall_cnt(b_osc),
`endif
        .tile_cnt(b_tile_cnt));

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: beat c of a tile, zero padding for rows beyond nr.
    function automatic void mk_beats(input int n, input int ew, input logic [127:0] rw[8],
                                     input int nr, input bit bp, output logic [127:0] bt[8]);
        logic [127:0] m, e;
        m = (128'd1 << ew) - 128'd1;
        for (int c = 0; c < 8; c++) bt[c] = '0;
        for (int c = 0; c < n; c++)
            for (int r = 0; r < n; r++) begin
                if (bp) e = (c < nr) ? ((rw[c] >> (r*ew)) & m) : '0;
                else    e = (r < nr) ? ((rw[r] >> (c*ew)) & m) : '0;
                bt[c] |= e << (r*ew);
            end
    endfunction

    logic [128:0] a_q[$], b_q[$];
    logic [127:0] a_seen[$];
    logic [127:0] a_rw[8], b_rw[8];
    int a_nr = 0, b_nr = 0, a_acc = 0;
    bit a_byp, b_byp;
    int b_isc_m = 0, b_osc_m = 0;

    always @(negedge clk) begin : mon_a
        logic [128:0] e;
        logic [127:0] bt[8];
        if (a_reset || a_clear) begin
            a_nr = 0;
            a_q.delete();
        end else begin
            if (a_out_vld && a_out_rdy) begin
                a_seen.push_back(128'(a_out_data));
                if (a_q.size() == 0) chk("a_underflow", 1, 0);
                else begin
                    e = a_q.pop_front();
                    chk("a_data", 128'(a_out_data), e[127:0]);
                    chk("a_last", a_out_last, e[128]);
                    chk("a_done", a_tile_done, e[128]);
                end
            end else if (a_tile_done) chk("a_done_idle", a_tile_done, 0);
            if (a_in_vld && a_in_rdy) begin
                if (a_nr == 0) a_byp = a_cfg_bypass;
                a_rw[a_nr] = 128'(a_in_data);
                a_nr++;
                a_acc++;
                if (a_in_last || a_nr == AN) begin
                    mk_beats(AN, AEW, a_rw, a_nr, a_byp, bt);
                    for (int c = 0; c < AN; c++) a_q.push_back({c == AN-1, bt[c]});
                    a_nr = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [128:0] e;
        logic [127:0] bt[8];
        if (b_reset || b_clear) begin
            b_nr = 0;
            b_q.delete();
            b_isc_m = 0;
            b_osc_m = 0;
        end else begin
`ifdef TILE_TRANSPOSER_STALL_CNT_EN
            chk("b_in_stall", b_isc, b_isc_m);
            chk("b_out_stall", b_osc, b_osc_m);
`endif
            if (b_in_vld && !b_in_rdy) b_isc_m++;
            if (b_out_vld && !b_out_rdy) b_osc_m++;
            if (b_out_vld && b_out_rdy) begin
                if (b_q.size() == 0) chk("b_underflow", 1, 0);
                else begin
                    e = b_q.pop_front();
                    chk("b_data", b_out_data, e[127:0]);
                    chk("b_last", b_out_last, e[128]);
                    chk("b_done", b_tile_done, e[128]);
                end
            end else if (b_tile_done) chk("b_done_idle", b_tile_done, 0);
            if (b_in_vld && b_in_rdy) begin
                if (b_nr == 0) b_byp = b_cfg_bypass;
                b_rw[b_nr] = b_in_data;
                b_nr++;
                if (b_in_last || b_nr == BN) begin
                    mk_beats(BN, BEW, b_rw, b_nr, b_byp, bt);
                    for (int c = 0; c < BN; c++) b_q.push_back({c == BN-1, bt[c]});
                    b_nr = 0;
                end
            end
        end
    end

    bit b_rnd = 0;
    always begin
        @(posedge clk);
        #1;
        if (b_rnd) b_out_rdy = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic a_row(input logic [31:0] d, input bit last, input bit bp);
        int k;
        a_in_data = d; a_in_last = last; a_cfg_bypass = bp; a_in_vld = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (a_in_rdy) break;
            k++;
            if (k > 300) begin chk("a_row_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        a_in_vld = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic a_drain();
        int k;
        k = 0;
        while ((a_q.size() != 0 || a_out_vld) && k < 500) begin @(negedge clk); k++; end
        chk("a_drain_timeout", k >= 500, 0);
    endtask

    task automatic b_drain();
        int k;
        k = 0;
        while ((b_q.size() != 0 || b_out_vld) && k < 2000) begin @(negedge clk); k++; end
        chk("b_drain_timeout", k >= 2000, 0);
    endtask

    task automatic a_rst();
        @(posedge clk); #1 a_reset = 1'b1;
        @(posedge clk); #1 a_reset = 1'b0;
        a_seen.delete();
    endtask

    logic [31:0] t1_rows[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    logic [31:0] t1_exp[4]  = '{32'h0C080400, 32'h0D090501, 32'h0E0A0602, 32'h0F0B0703};

    initial begin
        int base;
        a_reset = 1; a_clear = 0; a_cfg_bypass = 0; a_in_data = '0; a_in_last = 0;
        a_in_vld = 0; a_out_rdy = 0;
        b_reset = 1; b_clear = 0; b_cfg_bypass = 0; b_in_data = '0; b_in_last = 0;
        b_in_vld = 0; b_out_rdy = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", a_in_rdy, 0);
        chk("rst_out_vld", a_out_vld, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_tile_done", a_tile_done, 0);
        chk("rst_tile_cnt", a_tile_cnt, 0);
        chk("rst_out_data", a_out_data, 0);
        @(posedge clk); #1 a_reset = 0; b_reset = 0;
        @(negedge clk);
        chk("post_rst_in_rdy", a_in_rdy, 1);

        // Full tile, no backpressure
        @(posedge clk); #1 a_out_rdy = 1;
        for (int i = 0; i < 4; i++) a_row(t1_rows[i], 0, 0);
        a_drain();
        chk("t1_cnt", a_tile_cnt, 1);
        chk("t1_beats", a_seen.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_beat", a_seen[i], 128'(t1_exp[i]));

        // Partial tile of two rows
        a_rst();
        a_row(32'h44332211, 0, 0);
        a_row(32'h88776655, 1, 0);
        a_drain();
        chk("t2_beats", a_seen.size(), 4);
        chk("t2_beat0", a_seen[0], 128'h00005511);
        for (int i = 0; i < 4; i++) chk("t2_hi_zero", a_seen[i][31:16], 0);
        chk("t2_cnt", a_tile_cnt, 1);

        // Backpressure across three tiles
        a_rst();
        a_out_rdy = 0;
        base = a_acc;
        fork
            for (int i = 0; i < 12; i++)
                a_row({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 0, 0);
        join_none
        repeat (40) @(negedge clk);
        chk("t3_rows_held", a_acc - base, 8);
        chk("t3_in_rdy_low", a_in_rdy, 0);
        @(posedge clk); #1 a_out_rdy = 1;
        wait fork;
        a_drain();
        chk("t3_beats", a_seen.size(), 12);
        chk("t3_tile3_beat0", a_seen[8], 128'h2C282420);
        chk("t3_cnt", a_tile_cnt, 3);

        // Bypass tile followed by a transposed tile
        a_rst();
        for (int i = 0; i < 4; i++) a_row(t1_rows[i], 0, 1);
        for (int i = 0; i < 4; i++) a_row(t1_rows[i], 0, 0);
        a_drain();
        for (int i = 0; i < 4; i++) chk("t4_bypass", a_seen[i], 128'(t1_rows[i]));
        chk("t4_transpose", a_seen[4], 128'(t1_exp[0]));
        chk("t4_cnt", a_tile_cnt, 2);

        // Reset after five rows
        a_rst();
        a_out_rdy = 0;
        for (int i = 0; i < 5; i++) a_row(32'hDEAD0000 + i, 0, 0);
        a_reset = 1;
        @(negedge clk);
        chk("t5_vld_in_rst", a_out_vld, 0);
        chk("t5_rdy_in_rst", a_in_rdy, 0);
        @(posedge clk); #1 a_reset = 0;
        @(negedge clk);
        chk("t5_vld_after", a_out_vld, 0);
        chk("t5_cnt_after", a_tile_cnt, 0);
        chk("t5_rdy_after", a_in_rdy, 1);
        a_seen.delete();
        @(posedge clk); #1 a_out_rdy = 1;
        for (int i = 0; i < 4; i++) a_row(t1_rows[i], 0, 0);
        a_drain();
        chk("t5_beats", a_seen.size(), 4);
        chk("t5_new_beat0", a_seen[0], 128'(t1_exp[0]));
        chk("t5_cnt", a_tile_cnt, 1);

        // Soft clear with a partial tile pending
        a_out_rdy = 0;
        a_row(32'h11111111, 0, 0);
        a_row(32'h22222222, 0, 0);
        a_clear = 1;
        @(negedge clk);
        chk("clr_rdy_in", a_in_rdy, 0);
        @(posedge clk); #1 a_clear = 0;
        @(negedge clk);
        chk("clr_cnt", a_tile_cnt, 0);
        chk("clr_rdy_after", a_in_rdy, 1);
        a_seen.delete();
        @(posedge clk); #1 a_out_rdy = 1;
        a_row(32'h000000AB, 1, 0);
        a_drain();
        chk("clr_beat0", a_seen[0], 128'h000000AB);
        chk("clr_beat1", a_seen[1], 128'h0);

        // Random stream on the N=8 / EW=16 instance
        b_rnd = 1;
        for (int t = 0; t < 1000; t++) begin
            int nr;
            bit bp;
            nr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, BN)) : BN;
            bp = ($urandom_range(0, 3) == 0);
            for (int r = 0; r < nr; r++) begin
                int k;
                bit acc;
                b_in_data = {$urandom, $urandom, $urandom, $urandom};
                b_in_last = (r == nr-1) && (nr < BN || $urandom_range(0, 1) == 1);
                b_cfg_bypass = (r == 0) ? bp : 1'($urandom_range(0, 1));
                k = 0; acc = 0;
                while (!acc && k < 200) begin
                    b_in_vld = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    acc = b_in_vld && b_in_rdy;
                    @(posedge clk); #1;
                    k++;
                end
                if (!acc) chk("b_row_timeout", 0, 1);
                b_in_vld = 0;
            end
        end
        b_rnd = 0;
        @(posedge clk); #1 b_out_rdy = 1;
        b_drain();
        chk("b_cnt", b_tile_cnt, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
